prog_mem_server: RTL and testbench

//  Program-memory responder on the far end of the processor's instruction-fetch port.
//  A host loads a program into an internal DEPTH x 16 memory, after which the block pulses start.
//  It then answers each processor fetch (pc + ram_read_en) with the instruction word one cycle later.

---
 rtl/prog_mem_server.sv | 138 +++++++++++++
 tb/tb_prog_mem_server.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_server.sv
// Program-memory responder: a host streams a program into an internal RAM, then the block
// pulses start and serves the processor's instruction fetches with one cycle of latency.
module prog_mem_server #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_vld,
  output logic              load_rdy,
  output logic              load_err,
  output logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ram_read_en,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_vld,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_LEFT = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W:0]     len_reg_q, len_reg_d;
  logic [ADDR_W:0]     load_len_q, load_len_d;
  logic                load_rdy_q, load_rdy_d;
  logic                load_err_q, load_err_d;
  logic                start_q, start_d;
  logic                instr_vld_q;
  logic                hit_q;
  logic [DATA_W-1:0]   rd_word_q;
  logic                mem_we;
  logic                fetch;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign fetch = (state_q == RUN) && ram_read_en;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    len_reg_d   = len_reg_q;
    load_len_d  = load_len_q;
    load_rdy_d  = load_rdy_q;
    load_err_d  = 1'b0;
    start_d     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          if ((load_len != '0) && (load_len <= MAX_LEN)) begin
            state_d     = LOAD;
            wr_ptr_d    = '0;
            remaining_d = load_len;
            len_reg_d   = '0;
            load_len_d  = load_len;
            load_rdy_d  = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_vld && load_rdy_q) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == ONE_LEFT) begin
            state_d    = START;
            load_rdy_d = 1'b0;
            start_d    = 1'b1;
            len_reg_d  = load_len_q;
          end
        end
      end
      START:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      len_reg_q   <= '0;
      load_len_q  <= '0;
      load_rdy_q  <= 1'b0;
      load_err_q  <= 1'b0;
      start_q     <= 1'b0;
      instr_vld_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      len_reg_q   <= len_reg_d;
      load_len_q  <= load_len_d;
      load_rdy_q  <= load_rdy_d;
      load_err_q  <= load_err_d;
      start_q     <= start_d;
      instr_vld_q <= fetch;
      if (fetch) hit_q <= ({1'b0, pc} < len_reg_q);
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
  // hit_q (reset) masks stale contents, which also makes a discarded partial load read as zero.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= load_data;
    if (fetch)  rd_word_q     <= mem[pc];
  end

  assign load_rdy   = load_rdy_q;
  assign load_err   = load_err_q;
  assign start      = start_q;
  assign instr_vld  = instr_vld_q;
  assign instr_data = hit_q ? rd_word_q : '0;
  assign state      = state_q;

endmodule

// File: tb/tb_prog_mem_server.sv
// Self-checking bench for prog_mem_server: scoreboard of expected fetch responses
// (data and arrival cycle) checked by a negedge monitor.
module tb_prog_mem_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [10:0] load_len = '0;
  logic [15:0] load_data = '0;
  logic        load_vld = 1'b0;
  logic        load_rdy, load_err, start;
  logic [9:0]  pc = '0;
  logic        ram_read_en = 1'b0;
  logic [15:0] instr_data;
  logic        instr_vld;
  logic [1:0]  state;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_mem [1024];
  int          model_len = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  prog_mem_server dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .load_len(load_len), .load_data(load_data), .load_vld(load_vld),
    .load_rdy(load_rdy), .load_err(load_err), .start(start),
    .pc(pc), .ram_read_en(ram_read_en),
    .instr_data(instr_data), .instr_vld(instr_vld), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every instr_vld must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (instr_vld) begin
      if (sb_q.size() == 0) begin
        check("spurious_vld", 32'(instr_vld), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("instr_data", 32'(instr_data), 32'(e.data));
        check("instr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic fetch(input logic [9:0] a);
    exp_t e;
    pc          = a;
    ram_read_en = 1'b1;
    e.data      = (int'(a) < model_len) ? model_mem[a] : 16'h0000;
    e.cyc       = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    ram_read_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    model_len = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load len words base+1, base+2, ...; pat bit i is load_vld in loop cycle i (1 beyond plen).
  task automatic load_prog(input int len, input logic [15:0] base, input logic [15:0] pat,
                           input int plen);
    int beats = 0;
    int i = 0;
    @(negedge clk);
    load_req = 1'b1;
    load_len = len[10:0];
    @(negedge clk);
    load_req = 1'b0;
    check("load_state", 32'(state), 32'd1);
    while (beats < len && i < len + plen + 20) begin
      load_vld  = (i < plen) ? pat[i] : 1'b1;
      load_data = base + 16'(beats + 1);
      check("load_rdy", 32'(load_rdy), 32'd1);
      check("no_early_start", 32'(start), 32'd0);
      if (load_vld && load_rdy) begin
        model_mem[beats] = load_data;
        beats++;
      end
      i++;
      @(negedge clk);
    end
    load_vld = 1'b0;
    check("load_beats", beats, len);
    model_len = len;
    check("start_pulse", 32'(start), 32'd1);
    check("state_start", 32'(state), 32'd2);
    check("load_rdy_off", 32'(load_rdy), 32'd0);
    @(negedge clk);
    check("start_clear", 32'(start), 32'd0);
    check("state_run", 32'(state), 32'd3);
  endtask

  task automatic err_req(input int len);
    @(negedge clk);
    load_req = 1'b1;
    load_len = len[10:0];
    @(negedge clk);
    load_req = 1'b0;
    check("load_err_pulse", 32'(load_err), 32'd1);
    check("err_state", 32'(state), 32'd0);
    @(negedge clk);
    check("load_err_clear", 32'(load_err), 32'd0);
    check("err_no_start", 32'(start), 32'd0);
    check("err_load_rdy", 32'(load_rdy), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_load_rdy", 32'(load_rdy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_instr_vld", 32'(instr_vld), 32'd0);
    check("rst_instr_data", 32'(instr_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fetches outside RUN are ignored (monitor flags any instr_vld).
    ram_read_en = 1'b1;
    repeat (2) @(negedge clk);
    ram_read_en = 1'b0;

    // T2: four words, continuous load_vld.
    load_prog(4, 16'hA000, 16'hFFFF, 4);

    // T3/T4: back-to-back fetches, out-of-range pc, top address, then hold check.
    for (int a = 0; a < 4; a++) fetch(10'(a));
    fetch(10'd10);
    fetch(10'd1023);
    fetch(10'd2);
    drain();
    @(negedge clk);
    check("vld_low_idle", 32'(instr_vld), 32'd0);
    check("data_hold", 32'(instr_data), 32'hA003);

    // load_req in RUN is ignored.
    load_req = 1'b1;
    load_len = 11'd2;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    check("run_ignores_load", 32'(state), 32'd3);
    check("run_load_rdy", 32'(load_rdy), 32'd0);

    // T1: asynchronous reset mid-fetch drops the pending response.
    pc = 10'd0;
    ram_read_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    model_len = 0;
    #1;
    check("t1_state", 32'(state), 32'd0);
    check("t1_start", 32'(start), 32'd0);
    check("t1_instr_vld", 32'(instr_vld), 32'd0);
    check("t1_load_rdy", 32'(load_rdy), 32'd0);
    check("t1_instr_data", 32'(instr_data), 32'd0);
    @(negedge clk);
    ram_read_en = 1'b0;
    rst = 1'b0;

    // T5: illegal lengths.
    err_req(0);
    err_req(1025);

    // Reset mid-LOAD discards the partial program.
    @(negedge clk);
    load_req = 1'b1;
    load_len = 11'd2;
    @(negedge clk);
    load_req  = 1'b0;
    load_vld  = 1'b1;
    load_data = 16'hDEAD;
    @(negedge clk);
    load_vld = 1'b0;
    check("midload_state", 32'(state), 32'd1);
    rst = 1'b1;
    #1;
    check("midload_rst_state", 32'(state), 32'd0);
    check("midload_rst_rdy", 32'(load_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // T6: three words with load_vld gaps 1,0,0,1,1; pc 3 lies beyond the new length.
    load_prog(3, 16'h5B00, 16'b1_1001, 5);
    for (int a = 0; a < 4; a++) fetch(10'(a));
    drain();

    // Full-depth load; top address and wrap to 0.
    apply_reset();
    load_prog(1024, 16'h1000, 16'hFFFF, 0);
    fetch(10'd1023);
    fetch(10'd0);
    fetch(10'd511);
    drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
